// File: rtl/mips_ctrl_pkg.sv
// Shared encodings for the multi-cycle MIPS main control: opcodes, FSM state
// codes, ALU operation classes, datapath mux selects and the control word.
package mips_ctrl_pkg;

    localparam logic [5:0] OP_RTYPE = 6'b000000;
    localparam logic [5:0] OP_LW    = 6'b100011;
    localparam logic [5:0] OP_SW    = 6'b101011;
    localparam logic [5:0] OP_BEQ   = 6'b000100;
    localparam logic [5:0] OP_J     = 6'b000010;
    localparam logic [5:0] OP_ADDI  = 6'b001000;

    typedef enum logic [3:0] {
        S_FETCH     = 4'd0,
        S_DECODE    = 4'd1,
        S_MEM_ADDR  = 4'd2,
        S_MEM_RD    = 4'd3,
        S_MEM_WB    = 4'd4,
        S_MEM_WR    = 4'd5,
        S_R_EXEC    = 4'd6,
        S_R_WB      = 4'd7,
        S_BRANCH    = 4'd8,
        S_JUMP      = 4'd9,
        S_ADDI_EXEC = 4'd10,
        S_ADDI_WB   = 4'd11,
        S_HALT      = 4'd12
    } mc_state_e;

    localparam logic [1:0] ALUOP_ADD   = 2'b00;
    localparam logic [1:0] ALUOP_SUB   = 2'b01;
    localparam logic [1:0] ALUOP_FUNCT = 2'b10;

    // ALU B operand: register, constant 4, sign-extended imm, imm << 2
    localparam logic [1:0] SRCB_REG      = 2'b00;
    localparam logic [1:0] SRCB_FOUR     = 2'b01;
    localparam logic [1:0] SRCB_IMM      = 2'b10;
    localparam logic [1:0] SRCB_IMM_SHL2 = 2'b11;

    localparam logic [1:0] PCSRC_ALU    = 2'b00;
    localparam logic [1:0] PCSRC_ALUOUT = 2'b01;
    localparam logic [1:0] PCSRC_JUMP   = 2'b10;

    typedef struct packed {
        logic       pc_write;
        logic       pc_write_cond;
        logic       i_or_d;
        logic       mem_read;
        logic       mem_write;
        logic       ir_write;
        logic       reg_dst;
        logic       mem_to_reg;
        logic       reg_write;
        logic       alu_src_a;
        logic [1:0] alu_src_b;
        logic [1:0] pc_source;
        logic [1:0] alu_op;
        logic       halted;
    } mc_ctrl_t;

endpackage

// File: rtl/mc_ctrl_decode.sv
// State-to-control-word decode for the main control FSM. Optional addi states
// are decoded only when MC_CTRL_ADDI_EN is defined.
module mc_ctrl_decode
    import mips_ctrl_pkg::*;
(
    input  mc_state_e state,
    input  logic      mem_ready,
    input  logic      active,
    output mc_ctrl_t  ctrl
);

    always_comb begin
        ctrl = '0;
        if (active) begin
            case (state)
                S_FETCH: begin
                    ctrl.mem_read  = 1'b1;
                    ctrl.i_or_d    = 1'b0;
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = SRCB_FOUR;
                    ctrl.alu_op    = ALUOP_ADD;
                    ctrl.pc_source = PCSRC_ALU;
                    // IR and PC update only on the cycle memory delivers the word
                    ctrl.ir_write  = mem_ready;
                    ctrl.pc_write  = mem_ready;
                end
                S_DECODE: begin
                    ctrl.alu_src_a = 1'b0;
                    ctrl.alu_src_b = SRCB_IMM_SHL2;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEM_ADDR: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_MEM_RD: begin
                    ctrl.mem_read = 1'b1;
                    ctrl.i_or_d   = 1'b1;
                end
                S_MEM_WB: begin
                    ctrl.reg_dst    = 1'b0;
                    ctrl.mem_to_reg = 1'b1;
                    ctrl.reg_write  = 1'b1;
                end
                S_MEM_WR: begin
                    ctrl.mem_write = mem_ready;
                    ctrl.i_or_d    = 1'b1;
                end
                S_R_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_REG;
                    ctrl.alu_op    = ALUOP_FUNCT;
                end
                S_R_WB: begin
                    ctrl.reg_dst    = 1'b1;
                    ctrl.mem_to_reg = 1'b0;
                    ctrl.reg_write  = 1'b1;
                end
                S_BRANCH: begin
                    ctrl.alu_src_a     = 1'b1;
                    ctrl.alu_src_b     = SRCB_REG;
                    ctrl.alu_op        = ALUOP_SUB;
                    ctrl.pc_write_cond = 1'b1;
                    ctrl.pc_source     = PCSRC_ALUOUT;
                end
                S_JUMP: begin
                    ctrl.pc_write  = 1'b1;
                    ctrl.pc_source = PCSRC_JUMP;
                end
`ifdef MC_CTRL_ADDI_EN
                S_ADDI_EXEC: begin
                    ctrl.alu_src_a = 1'b1;
                    ctrl.alu_src_b = SRCB_IMM;
                    ctrl.alu_op    = ALUOP_ADD;
                end
                S_ADDI_WB: begin
                    ctrl.reg_dst    = 1'b0;
                    ctrl.mem_to_reg = 1'b0;
                    ctrl.reg_write  = 1'b1;
                end
`endif
                S_HALT: begin
                    ctrl.halted = 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: rtl/mc_main_control.sv
// Multi-cycle MIPS main control FSM (state register + next-state logic).
// Define MC_CTRL_ADDI_EN to add the addi instruction path.
module mc_main_control
    import mips_ctrl_pkg::*;
#(
    parameter int ILLEGAL_HALT = 1
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [5:0] opcode,
    input  logic       mem_ready,
    output logic       pc_write,
    output logic       pc_write_cond,
    output logic       i_or_d,
    output logic       mem_read,
    output logic       mem_write,
    output logic       ir_write,
    output logic       reg_dst,
    output logic       mem_to_reg,
    output logic       reg_write,
    output logic       alu_src_a,
    output logic [1:0] alu_src_b,
    output logic [1:0] pc_source,
    output logic [1:0] alu_op,
    output logic       halted,
    output logic [3:0] state
);

    localparam mc_state_e ILLEGAL_NEXT = (ILLEGAL_HALT != 0) ? S_HALT : S_FETCH;

    mc_state_e state_q;
    mc_state_e state_next;
    mc_ctrl_t  ctrl;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FETCH;
        end else begin
            state_q <= state_next;
        end
    end

    // Memory handshake: the FSM holds the request (mem_read / mem_write
    // asserted) for as many cycles as needed; mem_ready=1 marks the single
    // cycle the access completes, and only then do the memory states advance.
    always_comb begin
        state_next = state_q;
        case (state_q)
            S_FETCH:  if (mem_ready) state_next = S_DECODE;
            S_DECODE: begin
                case (opcode)
                    OP_RTYPE:     state_next = S_R_EXEC;
                    OP_LW, OP_SW: state_next = S_MEM_ADDR;
                    OP_BEQ:       state_next = S_BRANCH;
                    OP_J:         state_next = S_JUMP;
`ifdef MC_CTRL_ADDI_EN
                    OP_ADDI:      state_next = S_ADDI_EXEC;
`endif
                    default:      state_next = ILLEGAL_NEXT;
                endcase
            end
            S_MEM_ADDR: begin
                if (opcode == OP_LW) begin
                    state_next = S_MEM_RD;
                end else if (opcode == OP_SW) begin
                    state_next = S_MEM_WR;
                end else begin
                    state_next = ILLEGAL_NEXT;
                end
            end
            S_MEM_RD:  if (mem_ready) state_next = S_MEM_WB;
            S_MEM_WR:  if (mem_ready) state_next = S_FETCH;
            S_MEM_WB:  state_next = S_FETCH;
            S_R_EXEC:  state_next = S_R_WB;
            S_R_WB:    state_next = S_FETCH;
            S_BRANCH:  state_next = S_FETCH;
            S_JUMP:    state_next = S_FETCH;
`ifdef MC_CTRL_ADDI_EN
            S_ADDI_EXEC: state_next = S_ADDI_WB;
            S_ADDI_WB:   state_next = S_FETCH;
`endif
            S_HALT:    state_next = S_HALT;
            default:   state_next = S_FETCH;
        endcase
    end

    // Decode is gated by rst_n so every output reads 0 while reset is held.
    mc_ctrl_decode u_decode (
        .state     (state_q),
        .mem_ready (mem_ready),
        .active    (rst_n),
        .ctrl      (ctrl)
    );

    always_comb begin
        pc_write      = ctrl.pc_write;
        pc_write_cond = ctrl.pc_write_cond;
        i_or_d        = ctrl.i_or_d;
        mem_read      = ctrl.mem_read;
        mem_write     = ctrl.mem_write;
        ir_write      = ctrl.ir_write;
        reg_dst       = ctrl.reg_dst;
        mem_to_reg    = ctrl.mem_to_reg;
        reg_write     = ctrl.reg_write;
        alu_src_a     = ctrl.alu_src_a;
        alu_src_b     = ctrl.alu_src_b;
        pc_source     = ctrl.pc_source;
        alu_op        = ctrl.alu_op;
        halted        = ctrl.halted;
        state         = state_q;
    end

endmodule

// File: tb/tb_mc_main_control.sv
// Bench for mc_main_control: two instances (ILLEGAL_HALT=1 and =0) on shared
// stimulus, an instruction-path model, a write-strobe scoreboard and directed cases.
module tb_mc_main_control;

    // ---------------- clock / reset ----------------
    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic [5:0] opcode = 6'd0;
    logic       mem_ready = 1'b0;

    always #5 clk = ~clk;

    int total = 0;
    int bad = 0;

    // ---------------- DUT with ILLEGAL_HALT=1 ----------------
    logic h_pc_write, h_pc_write_cond, h_i_or_d, h_mem_read, h_mem_write, h_ir_write;
    logic h_reg_dst, h_mem_to_reg, h_reg_write, h_alu_src_a, h_halted;
    logic [1:0] h_alu_src_b, h_pc_source, h_alu_op;
    logic [3:0] h_state;
    logic [16:0] obs_h;

    mc_main_control #(.ILLEGAL_HALT(1)) dut_h (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(h_pc_write), .pc_write_cond(h_pc_write_cond), .i_or_d(h_i_or_d),
        .mem_read(h_mem_read), .mem_write(h_mem_write), .ir_write(h_ir_write),
        .reg_dst(h_reg_dst), .mem_to_reg(h_mem_to_reg), .reg_write(h_reg_write),
        .alu_src_a(h_alu_src_a), .alu_src_b(h_alu_src_b), .pc_source(h_pc_source),
        .alu_op(h_alu_op), .halted(h_halted), .state(h_state)
    );

    assign obs_h = {h_pc_write, h_pc_write_cond, h_i_or_d, h_mem_read, h_mem_write, h_ir_write,
                    h_reg_dst, h_mem_to_reg, h_reg_write, h_alu_src_a, h_alu_src_b,
                    h_pc_source, h_alu_op, h_halted};

    // ---------------- DUT with ILLEGAL_HALT=0 ----------------
    logic n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write;
    logic n_reg_dst, n_mem_to_reg, n_reg_write, n_alu_src_a, n_halted;
    logic [1:0] n_alu_src_b, n_pc_source, n_alu_op;
    logic [3:0] n_state;
    logic [16:0] obs_n;

    mc_main_control #(.ILLEGAL_HALT(0)) dut_n (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .mem_ready(mem_ready),
        .pc_write(n_pc_write), .pc_write_cond(n_pc_write_cond), .i_or_d(n_i_or_d),
        .mem_read(n_mem_read), .mem_write(n_mem_write), .ir_write(n_ir_write),
        .reg_dst(n_reg_dst), .mem_to_reg(n_mem_to_reg), .reg_write(n_reg_write),
        .alu_src_a(n_alu_src_a), .alu_src_b(n_alu_src_b), .pc_source(n_pc_source),
        .alu_op(n_alu_op), .halted(n_halted), .state(n_state)
    );

    assign obs_n = {n_pc_write, n_pc_write_cond, n_i_or_d, n_mem_read, n_mem_write, n_ir_write,
                    n_reg_dst, n_mem_to_reg, n_reg_write, n_alu_src_a, n_alu_src_b,
                    n_pc_source, n_alu_op, n_halted};

    // ---------------- checking helpers ----------------
    task automatic chk(input string name, input logic [31:0] got, input logic [31:0] exp);
        total++;
        if (got !== exp) begin
            bad++;
            $display("FAIL %s: got=%0h expected=%0h at t=%0t", name, got, exp, $time);
        end
    endtask

    // Control word each state must show; mr matters only for the memory-completion strobes.
    function automatic logic [16:0] exp_out(input int st, input logic mr);
        logic pcw, pcc, iod, mrd, mwr, irw, rdst, m2r, rw, asa, hlt;
        logic [1:0] asb, pcs, aop;
        pcw = 0; pcc = 0; iod = 0; mrd = 0; mwr = 0; irw = 0;
        rdst = 0; m2r = 0; rw = 0; asa = 0; hlt = 0;
        asb = 2'b00; pcs = 2'b00; aop = 2'b00;
        case (st)
            0:  begin mrd = 1; asb = 2'b01; irw = mr; pcw = mr; end
            1:  asb = 2'b11;
            2:  begin asa = 1; asb = 2'b10; end
            3:  begin mrd = 1; iod = 1; end
            4:  begin m2r = 1; rw = 1; end
            5:  begin mwr = mr; iod = 1; end
            6:  begin asa = 1; aop = 2'b10; end
            7:  begin rdst = 1; rw = 1; end
            8:  begin asa = 1; aop = 2'b01; pcc = 1; pcs = 2'b01; end
            9:  begin pcw = 1; pcs = 2'b10; end
            10: begin asa = 1; asb = 2'b10; end
            11: rw = 1;
            12: hlt = 1;
            default: ;
        endcase
        return {pcw, pcc, iod, mrd, mwr, irw, rdst, m2r, rw, asa, asb, pcs, aop, hlt};
    endfunction

    // Remaining states after DECODE, one nibble each (low first); a 0 nibble means back to FETCH.
    function automatic logic [15:0] seq_of(input logic [5:0] op, input bit ih);
        case (op)
            6'b100011: return 16'h0432;
            6'b101011: return 16'h0052;
            6'b000000: return 16'h0076;
            6'b000100: return 16'h0008;
            6'b000010: return 16'h0009;
`ifdef MC_CTRL_ADDI_EN
            6'b001000: return 16'h00BA;
`endif
            default:   return ih ? 16'h000C : 16'h0000;
        endcase
    endfunction

    // Write strobe each instruction must produce: 1 reg_write, 2 mem_write, 3 jump pc_write, 4 pc_write_cond.
    function automatic logic [2:0] ev_of(input logic [5:0] op);
        case (op)
            6'b100011, 6'b000000: return 3'd1;
            6'b101011: return 3'd2;
            6'b000010: return 3'd3;
            6'b000100: return 3'd4;
`ifdef MC_CTRL_ADDI_EN
            6'b001000: return 3'd1;
`endif
            default:   return 3'd0;
        endcase
    endfunction

    // ---------------- reference model ----------------
    int          mh = 0;
    int          mn = 0;
    logic [15:0] ph = '0;
    logic [15:0] pn = '0;
    logic [2:0]  exp_q[$];

    task automatic adv(inout int st, inout logic [15:0] p, input bit ih, input bit track);
        logic [2:0] ev;
        if (st == 12) begin
            st = 12;
        end else if ((st == 0 || st == 3 || st == 5) && !mem_ready) begin
            st = st;
        end else if (st == 0) begin
            st = 1;
        end else begin
            if (st == 1) begin
                p = seq_of(opcode, ih);
                ev = ev_of(opcode);
                if (track && ev != 3'd0) begin
                    chk("strobe_missing", 32'(exp_q.size()), 32'd0);
                    exp_q.push_back(ev);
                end
            end
            st = int'(p[3:0]);
            p = p >> 4;
        end
    endtask

    initial forever begin
        @(posedge clk or negedge rst_n);
        if (!rst_n) begin
            mh = 0;
            mn = 0;
            ph = '0;
            pn = '0;
            exp_q.delete();
        end else begin
            adv(mh, ph, 1'b1, 1'b1);
            adv(mn, pn, 1'b0, 1'b0);
        end
    end

    // ---------------- compare process ----------------
    initial forever begin
        logic [2:0] ev;
        @(negedge clk);
        chk("state_h", 32'(h_state), rst_n ? 32'(mh) : 32'd0);
        chk("outs_h", 32'(obs_h), rst_n ? 32'(exp_out(mh, mem_ready)) : 32'd0);
        chk("state_n", 32'(n_state), rst_n ? 32'(mn) : 32'd0);
        chk("outs_n", 32'(obs_n), rst_n ? 32'(exp_out(mn, mem_ready)) : 32'd0);
        if (h_reg_write) ev = 3'd1;
        else if (h_mem_write) ev = 3'd2;
        else if (h_pc_write && !h_mem_read) ev = 3'd3;
        else if (h_pc_write_cond) ev = 3'd4;
        else ev = 3'd0;
        if (ev != 3'd0) begin
            if (exp_q.size() == 0) chk("strobe_unexpected", 32'(ev), 32'd0);
            else chk("strobe_kind", 32'(ev), 32'(exp_q.pop_front()));
        end
    end

    // ---------------- driver tasks ----------------
    task automatic start_test(input logic [5:0] op, input logic mr);
        @(posedge clk); #1;
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_state", 32'(h_state), 32'd0);
        chk("rst_outs", 32'(obs_h), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        opcode = op;
        mem_ready = mr;
        @(negedge clk);
    endtask

    task automatic step(input logic mr);
        @(posedge clk); #1;
        mem_ready = mr;
        @(negedge clk);
    endtask

    function automatic logic [5:0] rand_op();
        int r;
        r = $urandom_range(0, 15);
        if (r < 3) return 6'b100011;
        if (r < 6) return 6'b101011;
        if (r < 9) return 6'b000000;
        if (r < 11) return 6'b000100;
        if (r < 13) return 6'b000010;
        if (r < 15) return 6'b001000;
        return 6'($urandom_range(0, 63));
    endfunction

    int lw_seq[6] = '{0, 1, 2, 3, 4, 0};
    int halt_cnt = 0;

    initial begin
        #200000;
        $display("FAIL watchdog: got=timeout expected=finish");
        $fatal(1, "watchdog expired");
    end

    // ---------------- directed + random stimulus ----------------
    initial begin
        int pulses;
        logic [15:0] strobes;
        logic rw_seen;
        #1 rst_n = 1'b0;

        // lw, memory always ready
        start_test(6'b100011, 1'b1);
        for (int i = 0; i < 6; i++) begin
            if (i > 0) step(1'b1);
            chk("lw_state", 32'(h_state), 32'(lw_seq[i]));
            chk("lw_reg_write", 32'(h_reg_write), (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) chk("lw_mem_to_reg", 32'(h_mem_to_reg), 32'd1);
        end

        // R-type
        start_test(6'b000000, 1'b1);
        step(1'b1); chk("r_decode", 32'(h_state), 32'd1);
        step(1'b1); chk("r_exec", 32'(h_state), 32'd6);
        chk("r_alu_op", 32'(h_alu_op), 32'd2);
        step(1'b1); chk("r_wb", 32'(h_state), 32'd7);
        chk("r_reg_dst", 32'(h_reg_dst), 32'd1);
        chk("r_reg_write", 32'(h_reg_write), 32'd1);
        step(1'b1); chk("r_back", 32'(h_state), 32'd0);

        // sw with three wait cycles in MEM_WR
        start_test(6'b101011, 1'b1);
        step(1'b1); chk("sw_decode", 32'(h_state), 32'd1);
        step(1'b1); chk("sw_addr", 32'(h_state), 32'd2);
        pulses = 0;
        for (int k = 0; k < 4; k++) begin
            step(k == 3);
            chk("sw_wait_state", 32'(h_state), 32'd5);
            pulses += int'(h_mem_write);
        end
        chk("sw_pulses", 32'(pulses), 32'd1);
        step(1'b1); chk("sw_back", 32'(h_state), 32'd0);

        // illegal opcode: halt vs nop
        start_test(6'b111111, 1'b1);
        step(1'b1); chk("ill_decode", 32'(h_state), 32'd1);
        step(1'b1);
        chk("ill_halt_state", 32'(h_state), 32'd12);
        chk("ill_halted", 32'(h_halted), 32'd1);
        chk("ill_nop_state", 32'(n_state), 32'd0);
        chk("ill_nop_halted", 32'(n_halted), 32'd0);
        strobes = '0;
        for (int k = 0; k < 20; k++) begin
            step(1'($urandom_range(0, 1)));
            chk("halt_sticky", 32'(h_state), 32'd12);
            strobes |= obs_h[16:1];
        end
        chk("halt_strobes", 32'(strobes), 32'd0);

        // reset while lw waits in MEM_RD
        start_test(6'b100011, 1'b1);
        step(1'b1);
        step(1'b1);
        step(1'b0); chk("rd_wait_state", 32'(h_state), 32'd3);
        #2 rst_n = 1'b0;
        #1;
        chk("rst_mid_state", 32'(h_state), 32'd0);
        chk("rst_mid_outs", 32'(obs_h), 32'd0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        mem_ready = 1'b0;
        rw_seen = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1'b0);
            chk("post_rst_fetch", 32'(h_state), 32'd0);
            rw_seen |= h_reg_write;
        end
        chk("post_rst_no_write", 32'(rw_seen), 32'd0);

        // addi
        start_test(6'b001000, 1'b1);
        step(1'b1); chk("addi_decode", 32'(h_state), 32'd1);
        step(1'b1);
`ifdef MC_CTRL_ADDI_EN
        chk("addi_exec", 32'(h_state), 32'd10);
        step(1'b1); chk("addi_wb", 32'(h_state), 32'd11);
        chk("addi_reg_write", 32'(h_reg_write), 32'd1);
        step(1'b1); chk("addi_back", 32'(h_state), 32'd0);
`else
        chk("addi_illegal", 32'(h_state), 32'd12);
`endif

        // randomized traffic against the model
        start_test(6'b100011, 1'b1);
        for (int i = 0; i < 3000; i++) begin
            @(posedge clk); #1;
            if (!rst_n) begin
                rst_n = 1'b1;
            end else if ($urandom_range(0, 199) == 0 || halt_cnt > 6) begin
                rst_n = 1'b0;
                halt_cnt = 0;
            end
            mem_ready = ($urandom_range(0, 3) != 0);
            if ((mh == 0 || mh == 12) && mn == 0) opcode = rand_op();
            halt_cnt = (mh == 12) ? halt_cnt + 1 : 0;
        end
        @(negedge clk);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
